// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART line-command parser:
// parser states, ASCII byte values and MIG app_cmd opcodes.
`timescale 1ns/1ps
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_OPSP,
    S_APRE,
    S_ADDR,
    S_DPRE,
    S_DATA,
    S_TAIL,
    S_ISSUE,
    S_ERR
  } state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_W_UC = 8'h57;
  localparam logic [7:0] ASCII_W_LC = 8'h77;
  localparam logic [7:0] ASCII_R_UC = 8'h52;
  localparam logic [7:0] ASCII_R_LC = 8'h72;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder: flags 0-9/a-f/A-F and returns the nibble value.
`timescale 1ns/1ps
module hex_nibble_decode (
  input  logic [7:0] data_in,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (data_in >= 8'h30 && data_in <= 8'h39) begin
      is_hex = 1'b1;
      nibble = 4'(data_in - 8'h30);
    end else if (data_in >= 8'h41 && data_in <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(data_in - 8'h37);
    end else if (data_in >= 8'h61 && data_in <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(data_in - 8'h57);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII line-command parser ("W <addr> <data>" / "R <addr>") emitting MIG-style requests.
// Optional byte echo to a TX stage is enabled by defining UART_CMD_ECHO_EN.
`timescale 1ns/1ps
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic              err_syntax,
  output logic              rx_overrun,
  output logic              echo_valid,
  input  logic              echo_ready,
  output logic [7:0]        echo_data
);

  localparam int ADDR_DIGITS = (ADDR_W + 3) / 4;
  localparam int DATA_DIGITS = (DATA_W + 3) / 4;
  localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] digit_cnt;
  logic             is_hex;
  logic [3:0]       nibble;
  logic             is_sp, is_trm;
  logic             start_line, shift_addr, shift_data, cnt_clr;
  logic [2:0]       op_sel;
  logic             enter_err, err_term;

  hex_nibble_decode u_hex (
    .data_in (rx_data),
    .is_hex  (is_hex),
    .nibble  (nibble)
  );

  assign is_sp     = (rx_data == ASCII_SP);
  assign is_trm    = is_term(rx_data);
  assign cmd_valid = (state == S_ISSUE);
  assign enter_err = (state_next == S_ERR) && (state != S_ERR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_line = 1'b0;
    op_sel     = CMD_WRITE;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      S_IDLE: if (rx_valid) begin
        if (rx_data == ASCII_W_UC || rx_data == ASCII_W_LC) begin
          state_next = S_OPSP;
          start_line = 1'b1;
          op_sel     = CMD_WRITE;
        end else if (rx_data == ASCII_R_UC || rx_data == ASCII_R_LC) begin
          state_next = S_OPSP;
          start_line = 1'b1;
          op_sel     = CMD_READ;
        end else if (!(is_sp || is_trm)) begin
          state_next = S_ERR;
        end
      end
      S_OPSP: if (rx_valid) state_next = is_sp ? S_APRE : S_ERR;
      S_APRE: if (rx_valid) begin
        if (is_hex) begin
          state_next = S_ADDR;
          shift_addr = 1'b1;
        end else if (!is_sp) begin
          state_next = S_ERR;
        end
      end
      S_ADDR: if (rx_valid) begin
        if (is_hex) begin
          if (digit_cnt == CNT_W'(ADDR_DIGITS)) state_next = S_ERR;
          else                                  shift_addr = 1'b1;
        end else if (is_sp) begin
          state_next = (cmd_op == CMD_WRITE) ? S_DPRE : S_TAIL;
          cnt_clr    = 1'b1;
        end else if (is_trm) begin
          state_next = (cmd_op == CMD_READ) ? S_ISSUE : S_ERR;
        end else begin
          state_next = S_ERR;
        end
      end
      S_DPRE: if (rx_valid) begin
        if (is_hex) begin
          state_next = S_DATA;
          shift_data = 1'b1;
        end else if (!is_sp) begin
          state_next = S_ERR;
        end
      end
      S_DATA: if (rx_valid) begin
        if (is_hex) begin
          if (digit_cnt == CNT_W'(DATA_DIGITS)) state_next = S_ERR;
          else                                  shift_data = 1'b1;
        end else if (is_sp) begin
          state_next = S_TAIL;
        end else if (is_trm) begin
          state_next = S_ISSUE;
        end else begin
          state_next = S_ERR;
        end
      end
      S_TAIL: if (rx_valid) begin
        if (is_trm)      state_next = S_ISSUE;
        else if (!is_sp) state_next = S_ERR;
      end
      S_ISSUE: if (cmd_ready) state_next = S_IDLE;
      // A terminator that itself caused the error already ends the line.
      S_ERR: if (err_term || (rx_valid && is_trm)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_op     <= CMD_WRITE;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      digit_cnt  <= '0;
      err_syntax <= 1'b0;
      err_term   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (start_line) begin
        cmd_op    <= op_sel;
        cmd_addr  <= '0;
        cmd_wdata <= '0;
        digit_cnt <= '0;
      end else if (shift_addr) begin
        cmd_addr  <= {cmd_addr[ADDR_W-5:0], nibble};
        digit_cnt <= digit_cnt + CNT_W'(1);
      end else if (shift_data) begin
        cmd_wdata <= {cmd_wdata[DATA_W-5:0], nibble};
        digit_cnt <= digit_cnt + CNT_W'(1);
      end else if (cnt_clr) begin
        digit_cnt <= '0;
      end
      err_syntax <= enter_err;
      err_term   <= enter_err && rx_valid && is_trm;
      rx_overrun <= rx_valid && (state == S_ISSUE);
    end
  end

`ifdef UART_CMD_ECHO_EN
  // Newest byte wins: an unacknowledged echo byte is simply overwritten.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      echo_valid <= 1'b0;
      echo_data  <= 8'h00;
    end else if (rx_valid) begin
      echo_valid <= 1'b1;
      echo_data  <= rx_data;
    end else if (echo_ready) begin
      echo_valid <= 1'b0;
    end
  end
`else
  logic unused_echo_ready;
  assign unused_echo_ready = echo_ready;
  assign echo_valid        = 1'b0;
  assign echo_data         = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table of command lines plus directed
// handshake, overrun, reset and echo sequences (echo expectations follow UART_CMD_ECHO_EN).
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  logic         clk = 1'b0;
  logic         rstn;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [28:0]  cmd_addr;
  logic [255:0] cmd_wdata;
  logic         err_syntax;
  logic         rx_overrun;
  logic         echo_valid;
  logic         echo_ready;
  logic [7:0]   echo_data;

  int nChecks = 0;
  int nFails  = 0;

  int           reqCnt = 0, errCnt = 0, ovrCnt = 0;
  logic [2:0]   lastOp;
  logic [28:0]  lastAddr;
  logic [255:0] lastWdata;
  logic [7:0]   echoQ[$];

  typedef struct {
    string        line;
    int           expReq;
    logic [2:0]   expOp;
    logic [28:0]  expAddr;
    logic [255:0] expWdata;
    int           expErr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  uart_cmd_parser #(.ADDR_W(29), .DATA_W(256)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .err_syntax (err_syntax),
    .rx_overrun (rx_overrun),
    .echo_valid (echo_valid),
    .echo_ready (echo_ready),
    .echo_data  (echo_data)
  );

  // Passive monitor: counts accepted requests and pulses, keeps the last request.
  always @(posedge clk) begin
    if (rstn) begin
      if (cmd_valid && cmd_ready) begin
        reqCnt    <= reqCnt + 1;
        lastOp    <= cmd_op;
        lastAddr  <= cmd_addr;
        lastWdata <= cmd_wdata;
      end
      if (err_syntax) errCnt <= errCnt + 1;
      if (rx_overrun) ovrCnt <= ovrCnt + 1;
      if (echo_valid && echo_ready) echoQ.push_back(echo_data);
    end
  end

  function automatic vec_t mk(string l, int r, logic [2:0] op, logic [28:0] a,
                              logic [255:0] d, int e);
    vec_t v;
    v.line = l; v.expReq = r; v.expOp = op; v.expAddr = a; v.expWdata = d; v.expErr = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  initial begin
    string f64, f65;
    int r0, e0, o0, q0;

    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b1; echo_ready = 1'b1;

    f64 = "";
    for (int i = 0; i < 64; i++) f64 = {f64, "F"};
    f65 = {f64, "F"};

    vecs.push_back(mk("W 10 CAFEBABE\015", 1, 3'b000, 29'h10, 256'hCAFEBABE, 0));
    vecs.push_back(mk("W 10\015", 0, 3'b000, 29'h0, 256'h0, 1));
    vecs.push_back(mk("R 4\015", 1, 3'b001, 29'h4, 256'h0, 0));
    vecs.push_back(mk("R 123456789\015", 0, 3'b000, 29'h0, 256'h0, 1));
    vecs.push_back(mk("R 1\015", 1, 3'b001, 29'h1, 256'h0, 0));
    vecs.push_back(mk("w  ab   12  \015\012", 1, 3'b000, 29'hAB, 256'h12, 0));
    vecs.push_back(mk("R FFFFFFFF\012", 1, 3'b001, 29'h1FFFFFFF, 256'h0, 0));
    vecs.push_back(mk("X\015", 0, 3'b000, 29'h0, 256'h0, 1));
    vecs.push_back(mk("R 12 3\015", 0, 3'b000, 29'h0, 256'h0, 1));
    vecs.push_back(mk({"W 0 ", f64, "\015"}, 1, 3'b000, 29'h0, {256{1'b1}}, 0));
    vecs.push_back(mk({"W 0 ", f65, "\015"}, 0, 3'b000, 29'h0, 256'h0, 1));
    vecs.push_back(mk("\015\012  \012", 0, 3'b000, 29'h0, 256'h0, 0));
    vecs.push_back(mk("r 7 \015", 1, 3'b001, 29'h7, 256'h0, 0));

    repeat (3) @(negedge clk);
    checkOutput("reset cmd_valid", cmd_valid, 0);
    checkOutput("reset cmd_op", cmd_op, 0);
    checkOutput("reset cmd_addr", cmd_addr, 0);
    checkOutput("reset cmd_wdata", cmd_wdata, 0);
    checkOutput("reset err_syntax", err_syntax, 0);
    checkOutput("reset rx_overrun", rx_overrun, 0);
    checkOutput("reset echo_valid", echo_valid, 0);
    checkOutput("reset echo_data", echo_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      r0 = reqCnt; e0 = errCnt; o0 = ovrCnt;
      applyStimulus(vecs[k].line);
      repeat (6) @(negedge clk);
      checkOutput($sformatf("vec%0d req count", k), reqCnt - r0, vecs[k].expReq);
      checkOutput($sformatf("vec%0d err count", k), errCnt - e0, vecs[k].expErr);
      checkOutput($sformatf("vec%0d overrun", k), ovrCnt - o0, 0);
      if (vecs[k].expReq > 0) begin
        checkOutput($sformatf("vec%0d op", k), lastOp, vecs[k].expOp);
        checkOutput($sformatf("vec%0d addr", k), lastAddr, vecs[k].expAddr);
        checkOutput($sformatf("vec%0d wdata", k), lastWdata, vecs[k].expWdata);
      end
    end

    // Backpressure: request held 20 cycles, stray byte dropped with an overrun pulse.
    cmd_ready = 1'b0;
    r0 = reqCnt; e0 = errCnt; o0 = ovrCnt;
    applyStimulus("r 1fffffff");
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h0A;
    @(negedge clk);
    rx_valid = 1'b0;
    checkOutput("latency cmd_valid", cmd_valid, 1);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin rx_valid = 1'b1; rx_data = "X"; end
      else        rx_valid = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("held cmd_valid c%0d", c), cmd_valid, 1);
    end
    rx_valid = 1'b0;
    checkOutput("held op", cmd_op, 3'b001);
    checkOutput("held addr", cmd_addr, 29'h1FFFFFFF);
    checkOutput("held wdata", cmd_wdata, 0);
    cmd_ready = 1'b1;
    @(negedge clk);
    checkOutput("valid drop after accept", cmd_valid, 0);
    repeat (2) @(negedge clk);
    checkOutput("backpressure req count", reqCnt - r0, 1);
    checkOutput("overrun pulses", ovrCnt - o0, 1);
    checkOutput("dropped byte no err", errCnt - e0, 0);

    // Reset in the middle of a line discards it.
    r0 = reqCnt; e0 = errCnt;
    applyStimulus("W 5 ");
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("midreset cmd_addr", cmd_addr, 0);
    checkOutput("midreset cmd_valid", cmd_valid, 0);
    rstn = 1'b1;
    applyStimulus("\015");
    repeat (4) @(negedge clk);
    checkOutput("midreset req count", reqCnt - r0, 0);
    checkOutput("midreset err count", errCnt - e0, 0);

    // Echo path.
    q0 = echoQ.size();
    r0 = reqCnt;
    applyStimulus("R 1\015");
    repeat (4) @(negedge clk);
    checkOutput("echo line req", reqCnt - r0, 1);
`ifdef UART_CMD_ECHO_EN
    checkOutput("echo count", echoQ.size() - q0, 4);
    if (echoQ.size() - q0 == 4) begin
      checkOutput("echo byte0", echoQ[q0],     8'h52);
      checkOutput("echo byte1", echoQ[q0 + 1], 8'h20);
      checkOutput("echo byte2", echoQ[q0 + 2], 8'h31);
      checkOutput("echo byte3", echoQ[q0 + 3], 8'h0D);
    end
`else
    checkOutput("echo count disabled", echoQ.size() - q0, 0);
    checkOutput("echo_data disabled", echo_data, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
